time_entry: RTL and testbench
=============================

# time_entry

Digit-entry encoder that turns keypad-style BCD input (mm:ss) into a binary seconds count for the parking-meter timer. Digits shift in from the right, and the four echo outputs drive the 7-segment display path while the user types. On `commit`, the block validates the digits and converts them serially to `sec_count`, then delivers it with a one-cycle valid pulse. It is the inverse of the seconds-to-digits display conversion and sits between the button/keypad debouncers and the countdown counter load port.

## Interface
- `SEC_W`, 12: width of `sec_count`.
- `MAX_SEC`, 4095: largest accepted result; must be ≤ 2^SEC_W − 1.
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `digit_valid`  in  1  single-cycle strobe; `digit` is sampled this cycle
- `digit`  in  4  BCD digit, 0–9
- `clear`  in  1  single-cycle strobe; zero all digits
- `commit`  in  1  single-cycle strobe; start conversion
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each  echo of the entered digits
- `busy`  out  1  conversion in progress; inputs ignored
- `sec_count`  out  SEC_W  converted seconds, held until the next successful commit
- `sec_valid`  out  1  one-cycle pulse; `sec_count` is new
- `err`  out  1  one-cycle error pulse
- `err_code`  out  2  01 = digit > 9, 10 = `sec_tens` > 5, 11 = result > `MAX_SEC`; held until the next `err` pulse

## Operation
- **Reset values:** all digits 0, `sec_count` 0, `sec_valid` 0, `err` 0, `err_code` 00, `busy` 0, state ENTRY.
- **States:**
  - ENTRY: idle; accepts input.
  - S_HI: acc ← `min_tens`·10 + `min_ones`
  - S_MUL: acc ← acc·60
  - S_ST: acc ← acc + `sec_tens`·10
  - S_SO: acc ← acc + `sec_ones`
  - DONE: returns to ENTRY next cycle.
- **ENTRY input priority:** `clear` > `commit` > `digit_valid`. The losing strobe in the same cycle is dropped.
- **Digit shift:** on `digit_valid` with `digit` ≤ 9:
  - `min_tens` ← `min_ones`, `min_ones` ← `sec_tens`, `sec_tens` ← `sec_ones`, `sec_ones` ← `digit`.
  - The old `min_tens` is discarded.
- **Bad digit:** `digit` > 9 leaves the digits unchanged, pulses `err`, and sets `err_code` = 01.
- **Commit check:** if `sec_tens` > 5, pulse `err` with `err_code` = 10 and stay in ENTRY. No conversion runs.
- **Conversion path:** a valid commit goes ENTRY → S_HI → S_MUL → S_ST → S_SO → DONE → ENTRY.
- **Accumulator:** 13 bits, so 99:59 = 5999 fits.
  - ×10 is computed as (x<<3)+(x<<1).
  - ×60 is computed as (x<<6)−(x<<2).
  - No multiplier primitive is inferred.
- **DONE:**
  - If acc ≤ `MAX_SEC`: `sec_count` ← acc[SEC_W−1:0] and `sec_valid` pulses.
  - Otherwise: `err` pulses with `err_code` = 11, and `sec_count` is unchanged.
- **Digits across commit:** digits are retained after commit, whether it succeeds or fails. Only `clear` or `rst` zeroes them.
- **While busy:** `digit_valid`, `clear` and `commit` are ignored and not queued.
- **Reset mid-conversion:** returns to reset values next cycle. No `sec_valid` or `err` pulse is emitted.

## Timing
- **Cycle numbering:** `commit` is sampled in cycle 0. Cycles 1–4 are S_HI…S_SO, and cycle 5 is DONE.
- **`busy`:** high in cycles 1–5. It is registered and equals (state ≠ ENTRY).
- **`sec_valid` / range error:** the `sec_valid` or `err` (code 11) pulse occurs in cycle 6, one cycle after DONE. `sec_count` changes in the same cycle.
- **Commit latency:** 6 cycles from the `commit` edge to `sec_valid`.
- **Next accepted input:** cycle 6 is the earliest cycle in which a new input strobe is accepted.
- **Entry-time errors:** the `err` pulse for codes 01 and 10 occurs in the cycle after the offending strobe.
- **Echo outputs:** update in the cycle after an accepted `digit_valid` or `clear`.
- **Output registers:** all outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- **Shared package:** holds the state enum (ENTRY, S_HI, S_MUL, S_ST, S_SO, DONE), the `err_code` constants (ERR_NONE, ERR_DIGIT, ERR_SECT, ERR_RANGE) and the BCD digit width constant (4).
- **Sub-module:** one sub-module, `bcd_shift_reg`. It holds the four digit registers, the shift, and the clear logic.
- **Top level:** the FSM, accumulator datapath and output registers live in `time_entry`.

## Test plan
- **Digit entry and shift:** after reset, enter 1, 2, 3, 4 → echo 1/2/3/4. Enter 5 → echo 2/3/4/5.
- **Nominal conversion:** enter 0,5,3,0, then commit → `busy` in cycles 1–5, `sec_count` = 330 with `sec_valid` in cycle 6, `err` = 0.
- **Range checks:**
  - Enter 6,8,1,5 and commit → `sec_count` = 4095 and `sec_valid`.
  - Enter 6,8,1,6 and commit → `err` with code 11, and `sec_count` stays 4095.
- **Entry-time errors:**
  - Enter 0,1,7,0 and commit → `err` with code 10 the next cycle, no `busy`, no `sec_valid`.
  - `digit` = 10 → `err` with code 01, digits unchanged.
- **Priority and busy:**
  - `clear` and `commit` in the same cycle → digits zeroed, no conversion.
  - `digit_valid` during `busy` → ignored, and the result is unaffected.
- **Reset mid-conversion:** assert `rst` in cycle 3 of a conversion → all outputs return to reset values, no `sec_valid` pulse, and a later commit of 0,0,0,9 yields 9.

Source files
------------

// File: rtl/time_entry_pkg.sv
// Shared types and constants for the mm:ss digit-entry encoder.
// Holds the FSM state enum, error codes, digit width and the shift-add helpers.
// The helpers keep the x10 / x60 scaling as shifts and adds, so no multiplier is needed.
package time_entry_pkg;

    localparam int DIG_W = 4;
    // 13 bits holds the largest entry, 99:59 = 5999.
    localparam int ACC_W = 13;

    typedef enum logic [2:0] {
        ENTRY = 3'd0,
        S_HI  = 3'd1,
        S_MUL = 3'd2,
        S_ST  = 3'd3,
        S_SO  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_DIGIT = 2'b01;
    localparam logic [1:0] ERR_SECT  = 2'b10;
    localparam logic [1:0] ERR_RANGE = 2'b11;

    // x*10 = x*8 + x*2
    function automatic logic [ACC_W-1:0] times10(input logic [ACC_W-1:0] x);
        return (x << 3) + (x << 1);
    endfunction

    // x*60 = x*64 - x*4
    function automatic logic [ACC_W-1:0] times60(input logic [ACC_W-1:0] x);
        return (x << 6) - (x << 2);
    endfunction

endpackage

// File: rtl/time_entry_bcd_shift_reg.sv
// Four-digit BCD entry register: a new digit shifts in from the right, and the oldest digit is dropped.
// Latency: one cycle from a shift or clear to the updated outputs.
// No backpressure. The caller decides when shift/clear are allowed; clear wins over shift.
module bcd_shift_reg
    import time_entry_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             shift_i,
    input  logic             clear_i,
    input  logic [DIG_W-1:0] digit_i,
    output logic [DIG_W-1:0] min_tens_o,
    output logic [DIG_W-1:0] min_ones_o,
    output logic [DIG_W-1:0] sec_tens_o,
    output logic [DIG_W-1:0] sec_ones_o
);

    logic [DIG_W-1:0] min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;

    // Digit registers: zero on reset or clear, otherwise shift left one digit position.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            min_tens_q <= '0;
            min_ones_q <= '0;
            sec_tens_q <= '0;
            sec_ones_q <= '0;
        end else if (shift_i) begin
            min_tens_q <= min_ones_q;
            min_ones_q <= sec_tens_q;
            sec_tens_q <= sec_ones_q;
            sec_ones_q <= digit_i;
        end
    end

    assign min_tens_o = min_tens_q;
    assign min_ones_o = min_ones_q;
    assign sec_tens_o = sec_tens_q;
    assign sec_ones_o = sec_ones_q;

endmodule

// File: rtl/time_entry.sv
// Keypad mm:ss entry that is validated and converted serially to a binary seconds count.
// Latency: sec_valid (or a range err) arrives 6 cycles after commit; entry errors arrive 1 cycle after the strobe.
// No backpressure. Strobes are dropped while busy is high, and only one strobe is taken per cycle (clear > commit > digit).
module time_entry
    import time_entry_pkg::*;
#(
    parameter int SEC_W   = 12,
    parameter int MAX_SEC = 4095
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             digit_valid_i,
    input  logic [DIG_W-1:0] digit_i,
    input  logic             clear_i,
    input  logic             commit_i,
    output logic [DIG_W-1:0] min_tens_o,
    output logic [DIG_W-1:0] min_ones_o,
    output logic [DIG_W-1:0] sec_tens_o,
    output logic [DIG_W-1:0] sec_ones_o,
    output logic             busy_o,
    output logic [SEC_W-1:0] sec_count_o,
    output logic             sec_valid_o,
    output logic             err_o,
    output logic [1:0]       err_code_o
);

    state_t           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [SEC_W-1:0] sec_count_q;
    logic             sec_valid_q;
    logic             err_q;
    logic [1:0]       err_code_q;
    logic             busy_q;

    logic [DIG_W-1:0] min_tens, min_ones, sec_tens, sec_ones;
    logic             idle;
    logic             clr_en;
    logic             cmt_en;
    logic             dig_en;
    logic             dig_ok;

    // Input arbitration. Strobes are taken only in ENTRY, and the priority order is clear, then commit, then digit.
    assign idle   = (state_q == ENTRY);
    assign clr_en = idle && clear_i;
    assign cmt_en = idle && commit_i && !clear_i;
    assign dig_en = idle && digit_valid_i && !clear_i && !commit_i;
    assign dig_ok = (digit_i <= DIG_W'(9));

    bcd_shift_reg u_digits (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .shift_i    (dig_en && dig_ok),
        .clear_i    (clr_en),
        .digit_i    (digit_i),
        .min_tens_o (min_tens),
        .min_ones_o (min_ones),
        .sec_tens_o (sec_tens),
        .sec_ones_o (sec_ones)
    );

    // Conversion FSM with its accumulator and registered result/error outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ENTRY;
            acc_q       <= '0;
            sec_count_q <= '0;
            sec_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            busy_q      <= 1'b0;
        end else begin
            sec_valid_q <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                ENTRY: begin
                    if (cmt_en) begin
                        // A seconds-tens digit above 5 is not a valid time, so the conversion is never started.
                        if (sec_tens > DIG_W'(5)) begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_SECT;
                        end else begin
                            state_q <= S_HI;
                            busy_q  <= 1'b1;
                        end
                    end else if (dig_en && !dig_ok) begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_DIGIT;
                    end
                end
                S_HI: begin
                    acc_q   <= times10(ACC_W'(min_tens)) + ACC_W'(min_ones);
                    state_q <= S_MUL;
                end
                S_MUL: begin
                    acc_q   <= times60(acc_q);
                    state_q <= S_ST;
                end
                S_ST: begin
                    acc_q   <= acc_q + times10(ACC_W'(sec_tens));
                    state_q <= S_SO;
                end
                S_SO: begin
                    acc_q   <= acc_q + ACC_W'(sec_ones);
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= ENTRY;
                    busy_q  <= 1'b0;
                    if (acc_q <= ACC_W'(MAX_SEC)) begin
                        sec_count_q <= acc_q[SEC_W-1:0];
                        sec_valid_q <= 1'b1;
                    end else begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_RANGE;
                    end
                end
                default: begin
                    state_q <= ENTRY;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign min_tens_o  = min_tens;
    assign min_ones_o  = min_ones;
    assign sec_tens_o  = sec_tens;
    assign sec_ones_o  = sec_ones;
    assign busy_o      = busy_q;
    assign sec_count_o = sec_count_q;
    assign sec_valid_o = sec_valid_q;
    assign err_o       = err_q;
    assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_time_entry.sv
// Self-checking bench for time_entry: directed test-plan cases followed by randomized entry/commit traffic.
// The reference keeps the four digits in an array and computes mm*60+ss arithmetically.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_time_entry;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        digit_valid_i;
    logic [3:0]  digit_i;
    logic        clear_i;
    logic        commit_i;
    logic [3:0]  min_tens_o, min_ones_o, sec_tens_o, sec_ones_o;
    logic        busy_o;
    logic [11:0] sec_count_o;
    logic        sec_valid_o;
    logic        err_o;
    logic [1:0]  err_code_o;

    always #5 clk_i = ~clk_i;

    time_entry #(.SEC_W(12), .MAX_SEC(4095)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .digit_valid_i (digit_valid_i),
        .digit_i       (digit_i),
        .clear_i       (clear_i),
        .commit_i      (commit_i),
        .min_tens_o    (min_tens_o),
        .min_ones_o    (min_ones_o),
        .sec_tens_o    (sec_tens_o),
        .sec_ones_o    (sec_ones_o),
        .busy_o        (busy_o),
        .sec_count_o   (sec_count_o),
        .sec_valid_o   (sec_valid_o),
        .err_o         (err_o),
        .err_code_o    (err_code_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: md[0]=min tens .. md[3]=sec ones, plus last good count and last error code.
    int md[4];
    int exp_count = 0;
    int exp_code  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_echo(input string tag);
        chk({tag, "/min_tens"}, int'(min_tens_o), md[0]);
        chk({tag, "/min_ones"}, int'(min_ones_o), md[1]);
        chk({tag, "/sec_tens"}, int'(sec_tens_o), md[2]);
        chk({tag, "/sec_ones"}, int'(sec_ones_o), md[3]);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "/busy"},      int'(busy_o),      0);
        chk({tag, "/sec_valid"}, int'(sec_valid_o), 0);
        chk({tag, "/sec_count"}, int'(sec_count_o), exp_count);
        chk({tag, "/err_code"},  int'(err_code_o),  exp_code);
    endtask

    task automatic enter(input int d, input string tag);
        @(negedge clk_i);
        digit_valid_i = 1'b1;
        digit_i       = 4'(d);
        @(negedge clk_i);
        digit_valid_i = 1'b0;
        if (d <= 9) begin
            md[0] = md[1]; md[1] = md[2]; md[2] = md[3]; md[3] = d;
            chk({tag, "/err"}, int'(err_o), 0);
        end else begin
            exp_code = 1;
            chk({tag, "/err"}, int'(err_o), 1);
        end
        chk_echo(tag);
        chk_quiet(tag);
    endtask

    task automatic enter4(input int a, input int b, input int c, input int d, input string tag);
        enter(a, tag); enter(b, tag); enter(c, tag); enter(d, tag);
    endtask

    task automatic do_clear(input string tag);
        @(negedge clk_i);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        for (int i = 0; i < 4; i++) md[i] = 0;
        chk_echo(tag);
        chk({tag, "/err"}, int'(err_o), 0);
        chk_quiet(tag);
    endtask

    task automatic do_commit(input bit junk, input string tag);
        int val;
        val = (md[0] * 10 + md[1]) * 60 + md[2] * 10 + md[3];
        @(negedge clk_i);
        commit_i = 1'b1;
        @(negedge clk_i);
        commit_i = 1'b0;
        if (md[2] > 5) begin
            exp_code = 2;
            chk({tag, "/sect_err"}, int'(err_o), 1);
            chk_quiet(tag);
            chk_echo(tag);
            @(negedge clk_i);
            chk({tag, "/sect_err_end"}, int'(err_o), 0);
            chk_quiet({tag, "/after"});
            return;
        end
        for (int c = 1; c <= 5; c++) begin
            chk({tag, "/busy_c"},  int'(busy_o),      1);
            chk({tag, "/valid_c"}, int'(sec_valid_o), 0);
            chk({tag, "/err_c"},   int'(err_o),       0);
            if (junk) begin
                digit_valid_i = 1'($urandom_range(0, 1));
                digit_i       = 4'($urandom_range(0, 15));
                clear_i       = 1'($urandom_range(0, 1));
                commit_i      = 1'($urandom_range(0, 1));
            end
            @(negedge clk_i);
            digit_valid_i = 1'b0;
            clear_i       = 1'b0;
            commit_i      = 1'b0;
        end
        chk({tag, "/busy6"}, int'(busy_o), 0);
        if (val <= 4095) begin
            exp_count = val;
            chk({tag, "/sec_valid6"}, int'(sec_valid_o), 1);
            chk({tag, "/err6"},       int'(err_o),       0);
        end else begin
            exp_code = 3;
            chk({tag, "/sec_valid6"}, int'(sec_valid_o), 0);
            chk({tag, "/err6"},       int'(err_o),       1);
        end
        chk({tag, "/sec_count6"}, int'(sec_count_o), exp_count);
        chk({tag, "/err_code6"},  int'(err_code_o),  exp_code);
        chk_echo({tag, "/retained"});
        @(negedge clk_i);
        chk({tag, "/err7"}, int'(err_o), 0);
        chk_quiet({tag, "/c7"});
    endtask

    initial begin
        rst_i         = 1'b1;
        digit_valid_i = 1'b0;
        digit_i       = 4'd0;
        clear_i       = 1'b0;
        commit_i      = 1'b0;
        for (int i = 0; i < 4; i++) md[i] = 0;
        repeat (3) @(negedge clk_i);
        chk_echo("reset");
        chk("reset/err", int'(err_o), 0);
        chk_quiet("reset");
        rst_i = 1'b0;

        // Shift behaviour
        enter4(1, 2, 3, 4, "shift1234");
        enter(5, "shift5");

        // Nominal, boundary and range cases
        do_clear("clr_a");
        enter4(0, 5, 3, 0, "e0530");
        do_commit(1'b0, "conv330");
        do_clear("clr_b");
        enter4(6, 8, 1, 5, "e6815");
        do_commit(1'b0, "conv4095");
        do_clear("clr_c");
        enter4(6, 8, 1, 6, "e6816");
        do_commit(1'b0, "range_err");
        do_clear("clr_d");
        enter4(0, 1, 7, 0, "e0170");
        do_commit(1'b0, "sect_err");
        enter(10, "bad_digit");

        // clear and commit together: only the clear is taken
        @(negedge clk_i);
        clear_i  = 1'b1;
        commit_i = 1'b1;
        @(negedge clk_i);
        clear_i  = 1'b0;
        commit_i = 1'b0;
        for (int i = 0; i < 4; i++) md[i] = 0;
        chk_echo("clr_cmt");
        chk_quiet("clr_cmt");
        @(negedge clk_i);
        chk_quiet("clr_cmt2");

        // Strobes during busy are ignored
        enter4(1, 2, 3, 4, "e1234");
        do_commit(1'b1, "busy_junk");

        // Reset in cycle 3 of a conversion
        do_clear("clr_e");
        enter4(2, 2, 2, 2, "e2222");
        @(negedge clk_i);
        commit_i = 1'b1;
        @(negedge clk_i);
        commit_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) md[i] = 0;
        exp_count = 0;
        exp_code  = 0;
        chk_echo("mid_rst");
        chk("mid_rst/err", int'(err_o), 0);
        chk_quiet("mid_rst");
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            chk("mid_rst/no_valid", int'(sec_valid_o), 0);
            chk("mid_rst/no_err", int'(err_o), 0);
        end
        enter4(0, 0, 0, 9, "e0009");
        do_commit(1'b0, "conv9");

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 5)
                enter($urandom_range(0, 11), "rnd_digit");
            else if (r == 6)
                do_clear("rnd_clear");
            else
                do_commit(1'($urandom_range(0, 1)), "rnd_commit");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
